// File: rtl/mont_arb_pkg.sv
// mont_arb_pkg: shared definitions for the Montgomery multiplier arbiter.
//   - default operand width and watchdog depth
//   - FSM state encoding (IDLE=0, START=1, WAIT=2, RESP=3)
//   - requester port identifiers
package mont_arb_pkg;

    localparam int DEF_WIDTH   = 1024;
    localparam int DEF_TIMEOUT = 4096;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_START = S_START,
        ST_WAIT  = S_WAIT,
        ST_RESP  = S_RESP
    } arb_state_e;

    localparam logic ID_P0 = 1'b0;
    localparam logic ID_P1 = 1'b1;

endpackage

// File: rtl/mont_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick, purely combinational.
//   req_i[1:0]     request bits, bit n belongs to port n
//   last_id_i      port that received the most recent grant
//   grant_valid_o  at least one port is requesting
//   grant_id_o     winning port; on a tie the port not served last wins
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_id_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);

    assign grant_valid_o = req_i[0] | req_i[1];
    // A lone requester wins outright; a tie goes to the other port.
    assign grant_id_o    = (req_i[0] & req_i[1]) ? ~last_id_i : req_i[1];

endmodule

// File: rtl/mont_arbiter.sv
// mont_arbiter: shares one Montgomery multiplier between two requesters.
// Captures the winner's operands, pulses mm_start, waits for mm_done under a
// watchdog and returns the result on a shared, ID-tagged response bus.
//   clk, reset               clock, synchronous active-high reset
//   p0_*/p1_*                per-port req, operands (a, b, m) and gnt pulse
//   res_valid/id/data/timeout response pulse, owning port, result, watchdog flag
//   mm_start/a/b/m           multiplier start pulse and held operand registers
//   mm_result/mm_done        multiplier result and completion
//   mm_abort                 one-cycle pulse when the watchdog expires
//   dbg_state                current FSM state
//
// Request handshake: a port holds req high with stable operands until it sees
// its one-cycle gnt; gnt means the operands have been captured, and the port
// may drop req or change operands from the following cycle. req is only
// looked at in IDLE, so a req dropped before grant is never served.
module mont_arbiter
    import mont_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_req,
    input  logic [WIDTH-1:0] p0_a,
    input  logic [WIDTH-1:0] p0_b,
    input  logic [WIDTH-1:0] p0_m,
    output logic             p0_gnt,
    input  logic             p1_req,
    input  logic [WIDTH-1:0] p1_a,
    input  logic [WIDTH-1:0] p1_b,
    input  logic [WIDTH-1:0] p1_m,
    output logic             p1_gnt,
    output logic             res_valid,
    output logic             res_id,
    output logic [WIDTH:0]   res_data,
    output logic             res_timeout,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_m,
    input  logic [WIDTH:0]   mm_result,
    input  logic             mm_done,
    output logic             mm_abort,
    output logic [1:0]       dbg_state
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    arb_state_e       state_q;
    logic             last_id_q;
    logic             cur_id_q;
    logic [CW-1:0]    wd_cnt_q;
    logic [CW-1:0]    wd_cnt_d;
    logic             p0_gnt_q;
    logic             p1_gnt_q;
    logic             mm_start_q;
    logic             mm_abort_q;
    logic             res_valid_q;
    logic             res_id_q;
    logic             res_timeout_q;
    logic [WIDTH:0]   res_data_q;
    logic [WIDTH-1:0] mm_a_q;
    logic [WIDTH-1:0] mm_b_q;
    logic [WIDTH-1:0] mm_m_q;
    logic [WIDTH-1:0] mm_a_d;
    logic [WIDTH-1:0] mm_b_d;
    logic [WIDTH-1:0] mm_m_d;
    logic             arb_valid;
    logic             arb_id;

    rr_arb2 u_arb (
        .req_i         ({p1_req, p0_req}),
        .last_id_i     (last_id_q),
        .grant_valid_o (arb_valid),
        .grant_id_o    (arb_id)
    );

    // Operands of whichever port the arbiter currently favours.
    always_comb begin
        mm_a_d = p0_a;
        mm_b_d = p0_b;
        mm_m_d = p0_m;
        if (arb_id == ID_P1) begin
            mm_a_d = p1_a;
            mm_b_d = p1_b;
            mm_m_d = p1_m;
        end
    end

    // Saturates at WD_LAST by construction: WAIT leaves before incrementing past it.
    assign wd_cnt_d = wd_cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_id_q     <= ID_P1;     // so port 0 wins the first tie
            cur_id_q      <= ID_P0;
            wd_cnt_q      <= '0;
            p0_gnt_q      <= 1'b0;
            p1_gnt_q      <= 1'b0;
            mm_start_q    <= 1'b0;
            mm_abort_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_id_q      <= 1'b0;
            res_timeout_q <= 1'b0;
            res_data_q    <= '0;
            mm_a_q        <= '0;
            mm_b_q        <= '0;
            mm_m_q        <= '0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            p0_gnt_q    <= 1'b0;
            p1_gnt_q    <= 1'b0;
            mm_start_q  <= 1'b0;
            mm_abort_q  <= 1'b0;
            res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        mm_a_q    <= mm_a_d;
                        mm_b_q    <= mm_b_d;
                        mm_m_q    <= mm_m_d;
                        p0_gnt_q  <= (arb_id == ID_P0);
                        p1_gnt_q  <= (arb_id == ID_P1);
                        cur_id_q  <= arb_id;
                        last_id_q <= arb_id;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    mm_start_q <= 1'b1;
                    wd_cnt_q   <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion is checked first so a done on the last
                    // watchdog cycle still returns a real result.
                    if (mm_done) begin
                        res_data_q    <= mm_result;
                        res_timeout_q <= 1'b0;
                        res_id_q      <= cur_id_q;
                        res_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end else if (wd_cnt_q == WD_LAST) begin
                        res_data_q    <= '0;
                        res_timeout_q <= 1'b1;
                        res_id_q      <= cur_id_q;
                        res_valid_q   <= 1'b1;
                        mm_abort_q    <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        wd_cnt_q <= wd_cnt_d;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign p0_gnt      = p0_gnt_q;
    assign p1_gnt      = p1_gnt_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;
    assign res_data    = res_data_q;
    assign res_timeout = res_timeout_q;
    assign mm_start    = mm_start_q;
    assign mm_abort    = mm_abort_q;
    assign mm_a        = mm_a_q;
    assign mm_b        = mm_b_q;
    assign mm_m        = mm_m_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mont_arbiter.sv
// tb_mont_arbiter: directed bench for mont_arbiter with WIDTH=8, TIMEOUT=16
// and a behavioural multiplier whose latency is set per job.
module tb_mont_arbiter;

    localparam int W  = 8;
    localparam int TO = 16;
    localparam int RW = W + 3;      // {id, timeout, data[W:0]}

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         p0_req = 1'b0, p1_req = 1'b0;
    logic [W-1:0] p0_a = '0, p0_b = '0, p0_m = '0;
    logic [W-1:0] p1_a = '0, p1_b = '0, p1_m = '0;
    logic         p0_gnt, p1_gnt;
    logic         res_valid, res_id, res_timeout;
    logic [W:0]   res_data;
    logic         mm_start, mm_abort;
    logic [W-1:0] mm_a, mm_b, mm_m;
    logic [W:0]   mm_result;
    logic         mm_done;
    logic [1:0]   dbg_state;

    // ---------------- clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mont_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_a(p0_a), .p0_b(p0_b), .p0_m(p0_m), .p0_gnt(p0_gnt),
        .p1_req(p1_req), .p1_a(p1_a), .p1_b(p1_b), .p1_m(p1_m), .p1_gnt(p1_gnt),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .res_timeout(res_timeout), .mm_start(mm_start),
        .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done), .mm_abort(mm_abort),
        .dbg_state(dbg_state)
    );

    // ---------------- behavioural multiplier: done is high exactly mdl_lat
    // cycles after the mm_start cycle; mdl_lat == 0 means it never finishes.
    int         mdl_lat = 2;
    int         mdl_cnt = 0;
    logic       mdl_busy = 1'b0;
    logic       mdl_done = 1'b0;
    logic       inj_done = 1'b0;
    logic [W:0] mdl_res = '0;

    always @(posedge clk) begin
        if (reset || mm_abort) begin
            mdl_busy <= 1'b0;
            mdl_done <= 1'b0;
        end else begin
            mdl_done <= 1'b0;
            if (mm_start) begin
                mdl_busy <= 1'b1;
                mdl_cnt  <= 1;
            end else if (mdl_busy) begin
                if (mdl_lat != 0 && mdl_cnt == mdl_lat - 1) begin
                    mdl_done <= 1'b1;
                    mdl_busy <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt + 1;
                end
            end
        end
    end
    assign mm_result = mdl_res;
    assign mm_done   = mdl_done | inj_done;

    // ---------------- scoreboard
    int total = 0;
    int bad   = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_w;
    int res_cnt = 0, start_cnt = 0, abort_cnt = 0, unexp_cnt = 0, gnt_busy_cnt = 0;
    logic busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            busy = 1'b0;
        end else begin
            if (res_valid) begin
                res_cnt++;
                if (exp_q.size() == 0) begin
                    unexp_cnt++;
                end else begin
                    exp_w = exp_q.pop_front();
                    check("res_word", {res_id, res_timeout, res_data}, exp_w);
                end
                busy = 1'b0;
            end
            if (p0_gnt || p1_gnt) begin
                if (busy || (p0_gnt && p1_gnt)) gnt_busy_cnt++;
                busy = 1'b1;
            end
            if (mm_abort) abort_cnt++;
            if (mm_start) start_cnt++;
        end
    end

    // ---------------- driver tasks
    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {p0_gnt, p1_gnt, res_valid, res_id, res_timeout, mm_start, mm_abort}, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_mm_a"}, mm_a, 0);
        check({tag, "_mm_b"}, mm_b, 0);
        check({tag, "_mm_m"}, mm_m, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_gnt(input string tag, output logic id, output int at);
        logic seen;
        seen = 1'b0;
        id   = 1'b0;
        at   = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (p0_gnt || p1_gnt) begin
                seen = 1'b1;
                id   = p1_gnt;
                at   = cyc;
            end
        end
        check({tag, "_gnt_seen"}, seen, 1);
    endtask

    task automatic wait_res(input string tag, output int at);
        logic seen;
        seen = 1'b0;
        at   = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        check({tag, "_res_seen"}, seen, 1);
    endtask

    // ---------------- vector table
    typedef struct {
        logic       r0;
        logic       r1;
        logic [W-1:0] a0, b0, m0, a1, b1, m1;
        int         lat;
        logic [W:0] res;
        logic       exp_id;
        logic       exp_to;
        logic [W:0] exp_data;
        logic [W-1:0] exp_a, exp_b, exp_m;
        int         exp_lat;    // gnt cycle -> res_valid cycle
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        logic gid;
        int   gcyc, rcyc, prev_res, n_res, n_abort, n_start;
        string tag;

        vecs[0] = '{1'b1, 1'b0, 8'h03, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 10, 9'h01B,
                    1'b0, 1'b0, 9'h01B, 8'h03, 8'h05, 8'h07, 12};
        vecs[1] = '{1'b0, 1'b1, 8'h44, 8'h55, 8'h66, 8'h11, 8'h22, 8'h33, 4, 9'h155,
                    1'b1, 1'b0, 9'h155, 8'h11, 8'h22, 8'h33, 6};
        vecs[2] = '{1'b1, 1'b1, 8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 2, 9'h0FF,
                    1'b0, 1'b0, 9'h0FF, 8'hA0, 8'hA1, 8'hA2, 4};
        // done lands on the last watchdog cycle: result must win
        vecs[3] = '{1'b1, 1'b1, 8'hC0, 8'hC1, 8'hC2, 8'hD0, 8'hD1, 8'hD2, 15, 9'h1E5,
                    1'b1, 1'b0, 9'h1E5, 8'hD0, 8'hD1, 8'hD2, 17};
        // multiplier never finishes
        vecs[4] = '{1'b1, 1'b0, 8'h21, 8'h43, 8'h65, 8'hFF, 8'hFF, 8'hFF, 0, 9'h1FF,
                    1'b0, 1'b1, 9'h000, 8'h21, 8'h43, 8'h65, 17};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 3, 9'h0A5,
                    1'b1, 1'b0, 9'h0A5, 8'h12, 8'h34, 8'h56, 5};
        // done one cycle too late: timeout
        vecs[6] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 8'h3C, 8'h01, 8'h02, 8'h03, 16, 9'h123,
                    1'b0, 1'b1, 9'h000, 8'h0F, 8'hF0, 8'h3C, 17};
        vecs[7] = '{1'b1, 1'b0, 8'h80, 8'h7F, 8'hFE, 8'h00, 8'h00, 8'h00, 14, 9'h100,
                    1'b0, 1'b0, 9'h100, 8'h80, 8'h7F, 8'hFE, 16};

        // ---- reset state
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset = 1'b0;

        // ---- table-driven jobs
        for (int i = 0; i < NV; i++) begin
            tag = $sformatf("v%0d", i);
            p0_a = vecs[i].a0; p0_b = vecs[i].b0; p0_m = vecs[i].m0;
            p1_a = vecs[i].a1; p1_b = vecs[i].b1; p1_m = vecs[i].m1;
            p0_req  = vecs[i].r0;
            p1_req  = vecs[i].r1;
            mdl_lat = vecs[i].lat;
            mdl_res = vecs[i].res;
            exp_q.push_back({vecs[i].exp_id, vecs[i].exp_to, vecs[i].exp_data});
            wait_gnt(tag, gid, gcyc);
            check({tag, "_gnt_id"}, gid, vecs[i].exp_id);
            check({tag, "_start_early"}, mm_start, 0);
            p0_req = 1'b0;
            p1_req = 1'b0;
            @(negedge clk);
            check({tag, "_start"}, mm_start, 1);
            check({tag, "_mm_abm"}, {mm_a, mm_b, mm_m},
                  {vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_m});
            wait_res(tag, rcyc);
            check({tag, "_lat"}, rcyc - gcyc, vecs[i].exp_lat);
            check({tag, "_abort"}, mm_abort, vecs[i].exp_to);
        end

        // ---- stale done while idle
        @(negedge clk);
        n_res   = res_cnt;
        n_start = start_cnt;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (10) @(negedge clk);
        check("stale_done_res", res_cnt - n_res, 0);
        check("stale_done_start", start_cnt - n_start, 0);

        // ---- simultaneous requests right after reset
        do_reset();
        p0_a = 8'h31; p0_b = 8'h32; p0_m = 8'h33;
        p1_a = 8'h41; p1_b = 8'h42; p1_m = 8'h43;
        mdl_lat = 3;
        mdl_res = 9'h0C3;
        n_res = res_cnt;
        exp_q.push_back({1'b0, 1'b0, 9'h0C3});
        exp_q.push_back({1'b1, 1'b0, 9'h0C3});
        p0_req = 1'b1;
        p1_req = 1'b1;
        wait_gnt("sim0", gid, gcyc);
        check("sim0_id", gid, 0);
        p0_req = 1'b0;
        @(negedge clk);
        check("sim0_mm_a", mm_a, 8'h31);
        wait_res("sim0", rcyc);
        wait_gnt("sim1", gid, gcyc);
        check("sim1_id", gid, 1);
        check("sim1_turnaround", gcyc - rcyc, 2);
        p1_req = 1'b0;
        @(negedge clk);
        check("sim1_mm_a", mm_a, 8'h41);
        wait_res("sim1", rcyc);
        repeat (4) @(negedge clk);
        check("sim_res_count", res_cnt - n_res, 2);

        // ---- fairness with both requests held
        do_reset();
        mdl_lat = 2;
        mdl_res = 9'h077;
        p0_req = 1'b1;
        p1_req = 1'b1;
        prev_res = 0;
        for (int i = 0; i < 6; i++) begin
            tag = $sformatf("fair%0d", i);
            exp_q.push_back({logic'(i % 2), 1'b0, 9'h077});
            wait_gnt(tag, gid, gcyc);
            check({tag, "_id"}, gid, logic'(i % 2));
            if (i > 0) check({tag, "_gap"}, gcyc - prev_res, 2);
            if (i == 5) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
            wait_res(tag, rcyc);
            prev_res = rcyc;
        end

        // ---- reset in the middle of WAIT
        mdl_lat = 0;
        p0_req = 1'b1;
        wait_gnt("rw", gid, gcyc);
        check("rw_id", gid, 0);
        p0_req = 1'b0;
        repeat (4) @(negedge clk);
        n_res   = res_cnt;
        n_abort = abort_cnt;
        reset = 1'b1;
        @(negedge clk);
        check_zero("rw_after_rst");
        reset = 1'b0;
        repeat (24) @(negedge clk);
        check("rw_no_res", res_cnt - n_res, 0);
        check("rw_no_abort", abort_cnt - n_abort, 0);
        mdl_lat = 2;
        mdl_res = 9'h0AB;
        exp_q.push_back({1'b0, 1'b0, 9'h0AB});
        p0_req = 1'b1;
        p1_req = 1'b1;
        wait_gnt("rw_tie", gid, gcyc);
        check("rw_tie_id", gid, 0);
        p0_req = 1'b0;
        p1_req = 1'b0;
        wait_res("rw_tie", rcyc);
        repeat (4) @(negedge clk);

        // ---- final report
        check("unexpected_res", unexp_cnt, 0);
        check("gnt_overlap", gnt_busy_cnt, 0);
        check("exp_q_left", exp_q.size(), 0);
        check("abort_total", abort_cnt, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
